// File: rtl/vliw_regfile_sync.sv
// Multi-port VLIW register file: one write and three registered read ports per FU,
// with highest-FU-wins write arbitration, optional same-cycle bypass and optional zero register.
module vliw_regfile_sync #(
    parameter int NFU      = 2,
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NFU-1:0]            enable,
    input  logic [NFU-1:0]            writeEnable,
    input  logic [NFU-1:0][AW-1:0]    writeAddress,
    input  logic [NFU-1:0][XLEN-1:0]  inputData,
    input  logic [NFU-1:0][AW-1:0]    address1,
    input  logic [NFU-1:0][AW-1:0]    address2,
    input  logic [NFU-1:0][AW-1:0]    address3,
    output logic [NFU-1:0][XLEN-1:0]  outputData1,
    output logic [NFU-1:0][XLEN-1:0]  outputData2,
    output logic [NFU-1:0][XLEN-1:0]  outputData3,
    output logic [NFU-1:0]            writeConflict
);

    logic [XLEN-1:0] bank [NREG];

    logic [NFU-1:0]  wr_valid;
    logic [NFU-1:0]  wr_win;
    logic [NFU-1:0]  wr_lose;
    logic [AW-1:0]   rd_addr [3][NFU];
    logic [XLEN-1:0] rd_data [3][NFU];

    // Address maps to a real, writable/readable register (not out of range, not hardwired zero).
    function automatic logic live_reg(input logic [AW-1:0] a);
        return (32'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        wr_valid = '0;
        wr_win   = '0;
        for (int i = 0; i < NFU; i++) begin
            wr_valid[i] = enable[i] & writeEnable[i] & live_reg(writeAddress[i]);
        end
        // A valid write loses if any higher-index FU writes the same register.
        for (int i = 0; i < NFU; i++) begin
            wr_win[i] = wr_valid[i];
            for (int j = 0; j < NFU; j++) begin
                if (j > i && wr_valid[j] && (writeAddress[j] == writeAddress[i])) begin
                    wr_win[i] = 1'b0;
                end
            end
        end
        wr_lose = wr_valid & ~wr_win;
    end

    always_comb begin
        for (int i = 0; i < NFU; i++) begin
            rd_addr[0][i] = address1[i];
            rd_addr[1][i] = address2[i];
            rd_addr[2][i] = address3[i];
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NFU; i++) begin
                rd_data[k][i] = '0;
                if (live_reg(rd_addr[k][i])) begin
                    rd_data[k][i] = bank[rd_addr[k][i]];
                    // At most one winning write per address, so the forward is unambiguous.
                    if (BYPASS != 0) begin
                        for (int j = 0; j < NFU; j++) begin
                            if (wr_win[j] && (writeAddress[j] == rd_addr[k][i])) begin
                                rd_data[k][i] = inputData[j];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                bank[r] <= '0;
            end
            outputData1   <= '0;
            outputData2   <= '0;
            outputData3   <= '0;
            writeConflict <= '0;
        end else begin
            for (int i = 0; i < NFU; i++) begin
                if (wr_win[i]) begin
                    bank[writeAddress[i]] <= inputData[i];
                end
                if (enable[i]) begin
                    outputData1[i] <= rd_data[0][i];
                    outputData2[i] <= rd_data[1][i];
                    outputData3[i] <= rd_data[2][i];
                end
            end
            writeConflict <= wr_lose;
        end
    end

endmodule
